mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder serving the MDR/MAR pair.
- Accepts word read/write requests, inserts programmable wait states, then performs the access on an internal word array.
- Read data is returned on a held output that feeds the MDR's read-data input. Completion is signalled with a 4-phase done handshake; memDone can directly strobe the MDR read latch.

Parameters:
- DATA_W, 16, data word width (matches bus width).
- ADDR_W, 16, request address width (matches MAR width).
- DEPTH, 256, number of words in the array; power of two, >= 2.
- WAIT_CYCLES, 2, wait states inserted before each access; 0..15 allowed.

Ports:
- clk  input  1  single clock; all state on rising edge.
- resetN  input  1  asynchronous, active-low reset.
- addr  input  ADDR_W  word address from MAR; sampled at accept.
- readReq  input  1  read request level.
- writeReq  input  1  write request level.
- dToWriteIn  input  DATA_W  write data (MDR write-data output); sampled at accept.
- dReadOut  output  DATA_W  read data toward MDR read-data input; registered and held.
- memDone  output  1  access complete; held until both requests are low.
- memBusy  output  1  high from accept until return to IDLE.
- memErr  output  1  error flag, valid while memDone is high.

Behaviour:
- Reset (resetN low, async):
  - State goes to IDLE.
  - dReadOut=0, memDone=0, memBusy=0, memErr=0, wait counter=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On a clock edge with readReq|writeReq high: latch addr, dToWriteIn and op, and set memBusy=1.
  - Both requests high: read wins; the write is dropped, with no error.
  - Next state is WAIT, with counter loaded to WAIT_CYCLES-1. If WAIT_CYCLES=0, next state is ACCESS.
- WAIT: decrement the counter each cycle; on 0, go to ACCESS. Exactly WAIT_CYCLES cycles are spent in WAIT.
- ACCESS, one cycle:
  - Write: array[index] <= latched data; dReadOut unchanged.
  - Read: dReadOut <= array[index].
  - Then go to DONE.
- DONE:
  - memDone=1.
  - Stay while readReq|writeReq is high.
  - When both are low: memDone=0, memBusy=0, memErr=0, go to IDLE.
- Latency: memDone rises WAIT_CYCLES+2 rising edges after the accepting edge (default: 4). dReadOut is valid on the same edge memDone rises and stays stable until the next read's ACCESS.
- Index rule: index = latched addr[log2(DEPTH)-1:0]. Upper address bits are ignored when the feature below is off.
- Request changes after accept (addr, data, or toggling req) have no effect until DONE. A request deasserted mid-operation does not abort the access. A new request is accepted only from IDLE, so each access requires requests to drop first.
- Reset mid-operation: the operation is aborted immediately. A pending write that has not reached ACCESS never reaches the array.
- Read-after-write to the same address returns the new data.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined:
  - A latched addr >= DEPTH flags an error; ACCESS performs no array write.
  - A failed read loads dReadOut=0.
  - memErr=1 alongside memDone, cleared on return to IDLE.
  - Latency is unchanged.
- Undefined: memErr is tied 0 and addresses alias modulo DEPTH.

Decomposition:
- Shared package mem_pkg:
  - FSM state enum (IDLE/WAIT/ACCESS/DONE).
  - Op enum (OP_READ/OP_WRITE).
  - Default DATA_W/ADDR_W constants shared with the MDR/MAR.
- Sub-module mem_array: DEPTH x DATA_W, synchronous write enable, combinational read index, no reset. The responder registers the read result into dReadOut.

Test Plan:
- Reset, then write addr=0x0005, data=0xBEEF, drop writeReq, then read 0x0005 -> memDone 4 cycles after each accept; dReadOut=0xBEEF; memErr=0.
- WAIT_CYCLES=0 build, read addr=0x0010 after writing 0x1234 -> memDone 2 cycles after accept; dReadOut=0x1234.
- readReq and writeReq both high, addr=0x0003 holding 0x00AA, dToWriteIn=0x5555 -> dReadOut=0x00AA; array[3] still 0x00AA.
- Hold readReq high 6 cycles past memDone -> memDone stays 1, memBusy stays 1, no second access; drop req -> IDLE next edge.
- Write 0x7777 to addr 0x0020, assert resetN low during WAIT -> all outputs 0 asynchronously; later read of 0x0020 shows the prior value, not 0x7777.
- MEM_ADDR_CHECK_EN build, write then read addr=0x0100 (DEPTH=256) -> memErr=1 with memDone; dReadOut=0x0000; array[0] unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory responder and its MDR/MAR peers.
package mem_pkg;

  localparam int unsigned MemDataW = 16;
  localparam int unsigned MemAddrW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StDone
  } mem_state_e;

  typedef enum logic {
    OpRead,
    OpWrite
  } mem_op_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the MAR/MDR side (master) and the memory responder (slave).
interface mem_responder_if import mem_pkg::*; #(
  parameter int unsigned DATA_W = MemDataW,
  parameter int unsigned ADDR_W = MemAddrW
) ();

  logic [ADDR_W-1:0] addr;
  logic              readReq;
  logic              writeReq;
  logic [DATA_W-1:0] dToWriteIn;
  logic [DATA_W-1:0] dReadOut;
  logic              memDone;
  logic              memBusy;
  logic              memErr;

  modport master (
    output addr, readReq, writeReq, dToWriteIn,
    input  dReadOut, memDone, memBusy, memErr
  );

  modport slave (
    input  addr, readReq, writeReq, dToWriteIn,
    output dReadOut, memDone, memBusy, memErr
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_W word store: synchronous write, combinational read, contents never reset.
module mem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IdxW-1:0]   idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Wait-stated word responder with a 4-phase done handshake.
// Define MEM_ADDR_CHECK_EN to flag out-of-range addresses on memErr instead of aliasing.
module mem_responder import mem_pkg::*; #(
  parameter int unsigned DATA_W      = MemDataW,
  parameter int unsigned ADDR_W      = MemAddrW,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           resetN,
  mem_responder_if.slave bus
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [3:0]  WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req, addr_bad, arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign req = bus.readReq | bus.writeReq;

`ifdef MEM_ADDR_CHECK_EN
  logic bad_q, bad_d;

  always_comb begin
    bad_d = bad_q;
    if (state_q == StIdle && req) begin
      bad_d = (64'(bus.addr) >= 64'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bad_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
    end
  end

  assign addr_bad = bad_q;
`else
  logic unused_addr;
  assign unused_addr = ^bus.addr;
  assign addr_bad    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = done_q;
    err_d   = err_q;
    arr_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          // Read wins when both requests are high.
          op_d    = bus.readReq ? OpRead : OpWrite;
          idx_d   = bus.addr[IdxW-1:0];
          wdata_d = bus.dToWriteIn;
          cnt_d   = WaitLoad;
          state_d = (WAIT_CYCLES == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        if (op_q == OpWrite) begin
          arr_we = !addr_bad;
        end else begin
          rdata_d = addr_bad ? '0 : arr_rdata;
        end
        err_d   = addr_bad;
        state_d = StDone;
      end
      StDone: begin
        // memDone must be seen high before release, even if requests already dropped.
        done_d = 1'b1;
        if (done_q && !req) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      op_q    <= OpRead;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  assign bus.dReadOut = rdata_q;
  assign bus.memDone  = done_q;
  assign bus.memBusy  = (state_q != StIdle);
  assign bus.memErr   = err_q & done_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against an array-based reference model.
module tb_mem_responder;

  localparam int unsigned DataW      = 16;
  localparam int unsigned AddrW      = 16;
  localparam int unsigned Depth      = 256;
  localparam int unsigned WaitCycles = 2;
`ifdef MEM_ADDR_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DataW-1:0] ref_mem [Depth];
  logic [DataW-1:0] ref_dout;

  mem_responder_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

  mem_responder #(
    .DATA_W     (DataW),
    .ADDR_W     (AddrW),
    .DEPTH      (Depth),
    .WAIT_CYCLES(WaitCycles)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full access: request, wait for done, optional hold, release, back to idle.
  task automatic run_txn(input logic rd, input logic wr, input logic [AddrW-1:0] a,
                         input logic [DataW-1:0] d, input bit scramble, input int hold);
    int n;
    bit seen, bad;
    int idx;
    @(negedge clk);
    bus.addr       = a;
    bus.readReq    = rd;
    bus.writeReq   = wr;
    bus.dToWriteIn = d;
    @(posedge clk);
    #1;
    check_eq("busy_at_accept", 32'(bus.memBusy), 32'd1);
    check_eq("done_at_accept", 32'(bus.memDone), 32'd0);
    if (scramble) begin
      bus.addr       = AddrW'($urandom);
      bus.dToWriteIn = DataW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        bus.readReq  = 1'b0;
        bus.writeReq = 1'b0;
      end
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.memDone;
    end
    check_eq("done_latency", 32'(n), 32'(WaitCycles + 2));
    bad = ChkEn && (int'(a) >= int'(Depth));
    idx = int'(a) % int'(Depth);
    if (rd) begin
      ref_dout = bad ? '0 : ref_mem[idx];
    end else if (!bad) begin
      ref_mem[idx] = d;
    end
    check_eq("read_data", 32'(bus.dReadOut), 32'(ref_dout));
    check_eq("err_flag", 32'(bus.memErr), 32'(bad));
    if (bus.readReq | bus.writeReq) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check_eq("done_held", 32'(bus.memDone), 32'd1);
        check_eq("busy_held", 32'(bus.memBusy), 32'd1);
        check_eq("data_held", 32'(bus.dReadOut), 32'(ref_dout));
      end
    end
    bus.readReq  = 1'b0;
    bus.writeReq = 1'b0;
    @(posedge clk);
    #1;
    check_eq("done_release", 32'(bus.memDone), 32'd0);
    check_eq("busy_release", 32'(bus.memBusy), 32'd0);
    check_eq("err_release", 32'(bus.memErr), 32'd0);
    check_eq("data_stable", 32'(bus.dReadOut), 32'(ref_dout));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.addr       = '0;
    bus.readReq    = 1'b0;
    bus.writeReq   = 1'b0;
    bus.dToWriteIn = '0;
    ref_dout       = '0;
    #12;
    check_eq("rst_done", 32'(bus.memDone), 32'd0);
    check_eq("rst_busy", 32'(bus.memBusy), 32'd0);
    check_eq("rst_err", 32'(bus.memErr), 32'd0);
    check_eq("rst_data", 32'(bus.dReadOut), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Fill the whole array so every later read has a known reference value.
    for (int i = 0; i < int'(Depth); i++) begin
      run_txn(1'b0, 1'b1, AddrW'(i), DataW'($urandom), 1'b0, 0);
    end

    run_txn(1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 0);
    run_txn(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 0);
    check_eq("beef_read", 32'(bus.dReadOut), 32'h0000_BEEF);

    run_txn(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 0);
    run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 0);
    check_eq("raw_read", 32'(bus.dReadOut), 32'h0000_1234);

    run_txn(1'b0, 1'b1, 16'h0003, 16'h00AA, 1'b0, 0);
    run_txn(1'b1, 1'b1, 16'h0003, 16'h5555, 1'b0, 0);
    check_eq("both_req_read", 32'(bus.dReadOut), 32'h0000_00AA);
    run_txn(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 0);
    check_eq("both_req_nowrite", 32'(bus.dReadOut), 32'h0000_00AA);

    run_txn(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 6);

    // Reset while the write is still waiting: array must keep the old value.
    @(negedge clk);
    bus.addr       = 16'h0020;
    bus.dToWriteIn = 16'h7777;
    bus.writeReq   = 1'b1;
    @(posedge clk);
    #1;
    check_eq("busy_before_rst", 32'(bus.memBusy), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    check_eq("arst_done", 32'(bus.memDone), 32'd0);
    check_eq("arst_busy", 32'(bus.memBusy), 32'd0);
    check_eq("arst_err", 32'(bus.memErr), 32'd0);
    check_eq("arst_data", 32'(bus.dReadOut), 32'd0);
    ref_dout     = '0;
    bus.writeReq = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 0);

    run_txn(1'b0, 1'b1, 16'h0100, 16'hCAFE, 1'b0, 0);
    run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 0);
    run_txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 0);

    for (int t = 0; t < 300; t++) begin
      int unsigned sel;
      logic [AddrW-1:0] a;
      sel = $urandom_range(0, 3);
      a = ($urandom_range(0, 9) < 7) ? AddrW'($urandom_range(0, 15)) : AddrW'($urandom);
      run_txn(sel == 0 || sel == 2, sel != 0, a, DataW'($urandom),
              bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
